// File: rtl/queue_counter.sv
// Queue occupancy stage: synchronizes and debounces the entry/exit photocells
// and keeps a saturating person count with registered full/empty flags.
module queue_counter #(
  parameter int DEBOUNCE  = 4,
  parameter int MAX_COUNT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       back_sensor,
  input  logic       front_sensor,
  output logic [2:0] pcount,
  output logic       empty_flag,
  output logic       full_flag,
  output logic       ovf_pulse,
  output logic       unf_pulse
);

  localparam int            CW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE - 1);
  localparam logic [2:0]    PMAX   = 3'(MAX_COUNT);

  // bit 0 = entry (back) path, bit 1 = exit (front) path
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] s;
  logic [1:0] fall;

  assign raw = {front_sensor, back_sensor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic          f;
    logic [CW-1:0] cnt;

    // A passage completes when the debounced beam-broken level clears.
    assign fall[i] = f && !s[i] && (cnt == CNT_TC);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        f   <= 1'b0;
        cnt <= '0;
      end else if (s[i] == f) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        f   <= s[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic       entry;
  logic       exit_ev;
  logic [2:0] pcount_nxt;
  logic       ovf_nxt;
  logic       unf_nxt;

  assign entry   = fall[0];
  assign exit_ev = fall[1];

  always_comb begin
    pcount_nxt = pcount;
    ovf_nxt    = 1'b0;
    unf_nxt    = 1'b0;
    if (entry && !exit_ev) begin
      if (pcount == PMAX) ovf_nxt    = 1'b1;
      else                pcount_nxt = pcount + 3'd1;
    end else if (exit_ev && !entry) begin
      if (pcount == 3'd0) unf_nxt    = 1'b1;
      else                pcount_nxt = pcount - 3'd1;
    end
  end

  // Flags are derived from the next count so they never lag pcount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcount     <= 3'd0;
      empty_flag <= 1'b1;
      full_flag  <= 1'b0;
      ovf_pulse  <= 1'b0;
      unf_pulse  <= 1'b0;
    end else begin
      pcount     <= pcount_nxt;
      empty_flag <= (pcount_nxt == 3'd0);
      full_flag  <= (pcount_nxt == PMAX);
      ovf_pulse  <= ovf_nxt;
      unf_pulse  <= unf_nxt;
    end
  end

endmodule

// File: doc/queue_counter.md
Name: queue_counter

Overview:
- Upstream occupancy stage of the queue monitor.
- Takes two raw photocell inputs: back_sensor at the queue entry and front_sensor at the queue exit/teller side.
- Synchronizes and debounces both, and detects completed passages.
- Maintains the 3-bit person count pcount that drives the wait-time lookup stage, plus full/empty flags and error pulses.

Parameters:
- DEBOUNCE, 4: consecutive cycles a synchronized sensor level must differ from the filtered level before the filtered level changes. Legal range 1..255.
- MAX_COUNT, 7: saturation ceiling of pcount. Must be ≤7 because pcount is 3 bits.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- back_sensor  input  1  entry photocell, raw and asynchronous; 1 = beam broken
- front_sensor  input  1  exit photocell, raw and asynchronous; 1 = beam broken
- pcount  output  3  persons currently in queue, 0..MAX_COUNT
- empty_flag  output  1  1 when pcount==0
- full_flag  output  1  1 when pcount==MAX_COUNT
- ovf_pulse  output  1  one-cycle pulse: entry event rejected at full
- unf_pulse  output  1  one-cycle pulse: exit event rejected at empty

Behaviour:
- Reset (async assert, sync release on clk):
  - pcount=0, empty_flag=1, full_flag=0, ovf_pulse=0, unf_pulse=0.
  - Synchronizer flops=0, filtered levels=0, debounce counters=0.
  - Reset mid-operation discards all pending debounce progress and the count immediately.
- Per sensor, an identical path:
  - 2-flop synchronizer producing s.
  - Debounce counter cnt, wide enough for DEBOUNCE-1.
  - Filtered level f.
- Debounce rule, evaluated each edge:
  - If s==f: cnt<=0.
  - If s!=f and cnt==DEBOUNCE-1: f<=s, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Any pulse or glitch on s shorter than DEBOUNCE cycles never changes f.
- Event definition: a person has passed when f falls (1→0), i.e. the beam clears after a debounced break. A rising f produces no event. Event is combinational on the f-update condition, so it applies at the same edge f changes.
- Latency: raw level stable from before edge N → f changes at edge N+1+DEBOUNCE. On a falling transition, pcount/flags/pulses update at that same edge N+1+DEBOUNCE.
- Count update, per edge:
  - Entry only, pcount<MAX_COUNT: pcount+1.
  - Entry only, pcount==MAX_COUNT: hold, ovf_pulse=1 for one cycle.
  - Exit only, pcount>0: pcount-1.
  - Exit only, pcount==0: hold, unf_pulse=1 for one cycle.
  - Entry and exit same edge: pcount unchanged, no pulses, at any count including 0 and MAX_COUNT.
  - No event: hold; pulses return to 0.
- pcount never wraps.
- Flags are registered and track the post-update pcount in the same cycle; they are never stale.
- Sensor held broken across reset release: f rises after debounce; no event until the beam clears.
- Sensor stuck broken: no further events, count frozen for that direction.

Test Plan (DEBOUNCE=4, MAX_COUNT=7):
1. Reset with sensors low → pcount=0, empty_flag=1, full_flag=0, both pulses 0. Then back_sensor high 10 cycles, low: pcount=1 exactly 5 edges after the low is sampled (N+1+4), empty_flag=0.
2. Eight debounced entries from 0 → pcount steps 1..7, full_flag=1 after the 7th. 8th entry: pcount stays 7, ovf_pulse high exactly one cycle.
3. Exit at pcount=0 → pcount stays 0, unf_pulse one cycle. Then 3 entries and 1 exit → pcount=2.
4. back_sensor glitches of 1, 2 and 3 cycles (high then low) → no change to pcount, f or pulses. A 4-cycle break counts once.
5. Entry and exit falling f aligned to the same edge at pcount=3 → pcount stays 3. The same case at pcount=7 → stays 7, no ovf_pulse; at pcount=0 → stays 0, no unf_pulse.
6. rst_n asserted mid-debounce at pcount=5 → all outputs return to reset values immediately without a clock edge. With back_sensor held high through the release, no count until it goes low, then pcount=1.
